// File: rtl/spi_rx_frame_checker.sv
// spi_rx_frame_checker: reads one frame from the SPI rx FIFO and checks it against an incrementing pattern
module spi_rx_frame_checker #(
  parameter int DATA = 8,
  parameter int FRAME_LEN = 9,
  parameter logic [DATA-1:0] PATTERN_BASE = 8'h31,
  parameter int USEDW_W = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA-1:0]    rdata,
  input  logic [USEDW_W-1:0] usedw,
  output logic               rd,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [7:0]         err_count,
  output logic [7:0]         first_err_idx
);
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, READ = 3'd2, CMP = 3'd3, DONE = 3'd4;
  localparam int TW = $clog2(TIMEOUT + 2);
  logic [2:0]    state;
  logic [7:0]    idx;
  logic [TW-1:0] tcnt;
  logic          mis, last, tmo;
  assign mis  = rdata != PATTERN_BASE + DATA'(idx);
  assign last = idx == 8'(FRAME_LEN - 1);
  assign tmo  = TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  // frame sequencing: one registered read per byte, compare the byte the cycle after the read
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd            <= 1'b0;
      idx           <= '0;
      tcnt          <= '0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (abort) begin
      state <= IDLE;
      rd    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state         <= WAIT;
          idx           <= '0;
          tcnt          <= '0;
          pass          <= 1'b0;
          timeout       <= 1'b0;
          err_count     <= '0;
          first_err_idx <= '0;
        end
        WAIT: if (usedw != '0) begin
          state <= READ;
          rd    <= 1'b1;
        end else if (tmo) begin
          state   <= DONE;
          timeout <= 1'b1;
          pass    <= 1'b0;
        end else tcnt <= tcnt + 1'b1;
        READ: begin
          rd    <= 1'b0;
          state <= CMP;
        end
        CMP: begin
          tcnt <= '0;
          if (mis) err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          if (mis && err_count == 8'd0) first_err_idx <= idx;
          if (last) begin
            state <= DONE;
            pass  <= err_count == 8'd0 && !mis;
          end else begin
            idx   <= idx + 8'd1;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_rx_frame_checker.md
# spi_rx_frame_checker

Read-side controller for the SPI receive FIFO. On a start pulse it fetches one frame of `FRAME_LEN` bytes, one byte at a time, and compares each byte against an incrementing pattern. It then reports pass/fail, an error count, the index of the first mismatching byte, and whether it timed out. It sits between the SPI receive FIFO and the JTAG-visible status registers and is the only block that drives the FIFO read strobe.

## Interface
- `DATA`, 8: byte width of the FIFO data.
- `FRAME_LEN`, 9: bytes per frame, 1..255.
- `PATTERN_BASE`, 8'h31: expected value of byte 0; byte i must equal `PATTERN_BASE` + i mod 2^`DATA`.
- `USEDW_W`, 4: width of the FIFO fill-level input.
- `TIMEOUT`, 1024: maximum consecutive WAIT cycles before abandoning the frame; 0 disables the timeout.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to check a frame; accepted only in IDLE.
- `abort`  in  1  return to IDLE immediately, without `done`.
- `rdata`  in  `DATA`  FIFO read data, valid the cycle after `rd`.
- `usedw`  in  `USEDW_W`  FIFO fill level.
- `rd`  out  1  FIFO read strobe, registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on frame completion or timeout.
- `pass`  out  1  frame completed with zero mismatches and no timeout.
- `timeout`  out  1  frame abandoned on timeout.
- `err_count`  out  8  mismatching bytes in the last frame; saturates at 255.
- `first_err_idx`  out  8  index of the first mismatching byte; 0 if none.

## Operation
- States: IDLE, WAIT, READ, CMP, DONE.
- IDLE:
  - `start` → WAIT.
  - On acceptance: index, `err_count`, `first_err_idx`, `pass`, `timeout` and the timeout counter all clear to 0.
- WAIT:
  - `usedw` > 0 → READ.
  - Otherwise the timeout counter increments.
  - When `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT` → DONE with `timeout`=1.
- READ: `rd`=1 for exactly this cycle → CMP.
- CMP:
  - Compare `rdata` with `PATTERN_BASE` + index, sum truncated to `DATA` bits.
  - On mismatch: `err_count` increments (saturating). If it was 0 beforehand, `first_err_idx` ← index.
  - Timeout counter clears.
  - index = `FRAME_LEN`-1 → DONE; otherwise index increments → WAIT.
- DONE:
  - `done`=1 for one cycle.
  - `pass` = (`err_count`==0 && !`timeout`).
  - → IDLE.
- Result outputs hold their values from DONE until the next accepted `start`.
- `rd` is never asserted outside READ, so there is at most one outstanding read. A FIFO underflow is impossible because `usedw` is sampled in WAIT, after the previous read has already decremented it.
- `start` while `busy` is ignored.
- `abort`:
  - Highest priority after `rst`; in any state → IDLE next cycle, with `rd`=0 that cycle.
  - No `done` pulse; result outputs keep their partial values.
  - `abort` and `start` together in IDLE: `start` is ignored.
- Bytes already read are consumed; the block never rewinds the FIFO.
- `rst` in mid-frame: → IDLE, all outputs take their reset values, and FIFO contents are untouched.

## Timing
- Reset values: `rd`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `first_err_idx`=0, state IDLE.
- `start` sampled at edge T: `busy`=1 from T+1 (WAIT).
- `usedw` > 0 in WAIT at cycle t: `rd`=1 in cycle t+1, compare in t+2, WAIT or DONE in t+3.
- Minimum 3 cycles per byte. With the FIFO pre-filled, a frame takes 3·`FRAME_LEN` + 2 cycles from `start` to the `done` pulse.
- `done`, `pass` and `timeout` are valid in the same cycle; `busy`=0 the cycle after `done`.
- Timeout: `done` is asserted `TIMEOUT`+1 cycles after the last byte was compared (or after WAIT was entered, for the first byte) if `usedw` stays 0.

## Test plan
- FIFO pre-loaded with 31..39, then `start` → exactly 9 `rd` pulses, each separated by ≥2 cycles; `done` at cycle 29; `pass`=1, `err_count`=0.
- FIFO holds 31 32 00 34 35 36 37 38 FF → `pass`=0, `err_count`=2, `first_err_idx`=2.
- `PATTERN_BASE`=8'hFE, `FRAME_LEN`=4, data FE FF 00 01 → `pass`=1 (wrap-around).
- `TIMEOUT`=16, only 3 correct bytes loaded → `done` 17 cycles after the third compare; `timeout`=1, `pass`=0, `err_count`=0, FIFO empty.
- Bytes trickled in one every 10 cycles → `rd` never asserted while `usedw`=0, no underflow, `pass`=1. A second `start` pulse injected mid-frame → ignored.
- `abort` or `rst` asserted in READ on byte 4 → `rd` drops the next cycle and there is no `done`. After `rst`, all outputs are 0. A following `start` with a fresh 9-byte frame → `pass`=1.
